nor_bank_snapshot: RTL and testbench

Debug read-out block for the gate-level AGC model: captures a parallel snapshot of up to WIDTH internal nets driven by the NOR-gate primitives and streams it out as a framed byte sequence over a valid/ready interface to the host link (UART/USB bridge). It is the reader side of the gate fabric. Gates write nets on the clock edge; this block samples them on a trigger and serializes them so that bench and FPGA builds can inspect machine state without adding probes to every net.

---
 rtl/nor_bank_snapshot_if.sv | 10 +
 rtl/nor_bank_snapshot.sv | 200 ++++++++++++++++++++
 tb/tb_nor_bank_snapshot.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nor_bank_snapshot_if.sv
// Byte stream carrying snapshot frames from nor_bank_snapshot to the host link.
// The master drives out_data/out_valid; the slave answers with out_ready.
interface nor_bank_snapshot_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/nor_bank_snapshot.sv
// Samples up to WIDTH gate nets on a trigger and streams them out as a framed
// byte sequence: 0xA5, sequence number, NBYTES data bytes (LSB byte first) and,
// when the macro SNAPSHOT_CSUM_EN is defined, an XOR checksum byte.
// Triggers arriving while a frame is in flight are dropped and flagged in the
// sticky overrun bit; a trigger on the final byte's handshake starts the next
// frame back-to-back.
module nor_bank_snapshot #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     nets,
    input  logic                 trigger,
    input  logic                 clr_ovr,
    output logic                 busy,
    output logic                 overrun,
    nor_bank_snapshot_if.master  stream
);

    localparam int NBYTES = (WIDTH + 7) / 8;
    localparam int SNAP_W = NBYTES * 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [7:0] HEADER = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SEQ,
        S_DATA
`ifdef SNAPSHOT_CSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_seq;
    logic [7:0]         r_fseq;
    logic [SNAP_W-1:0]  r_snap;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_busy;
    logic               r_ovr;
`ifdef SNAPSHOT_CSUM_EN
    logic [7:0]         r_csum;
`endif

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [IDX_W-1:0]   w_idx_inc;
    logic [7:0]         w_data_nxt;
    logic               w_valid_nxt;
    logic               w_hs;
    logic               w_idx_last;
    logic               w_last;
    logic               w_accept;
    logic               w_drop;
    logic [SNAP_W-1:0]  w_snap_shift;

    assign w_hs         = r_valid && stream.out_ready;
    assign w_idx_last   = (r_idx == IDX_W'(NBYTES - 1));
    assign w_idx_inc    = r_idx + IDX_W'(1);
    assign w_snap_shift = r_snap >> {w_idx_inc, 3'b000};

    // The final byte of the frame is being handed over this cycle.
`ifdef SNAPSHOT_CSUM_EN
    assign w_last = w_hs && (r_state == S_CSUM);
`else
    assign w_last = w_hs && (r_state == S_DATA) && w_idx_last;
`endif

    // A trigger is taken when idle or when the current frame ends this cycle.
    assign w_accept = trigger && ((r_state == S_IDLE) || w_last);
    assign w_drop   = trigger && !w_accept;

    // Next state and next output byte; outputs are registered from these.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;

        case (r_state)
            S_IDLE: begin
            end
            S_HDR: begin
                if (w_hs) begin
                    w_state_nxt = S_SEQ;
                    w_data_nxt  = r_fseq;
                end
            end
            S_SEQ: begin
                if (w_hs) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = '0;
                    w_data_nxt  = r_snap[7:0];
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    if (w_idx_last) begin
`ifdef SNAPSHOT_CSUM_EN
                        w_state_nxt = S_CSUM;
                        w_data_nxt  = r_csum ^ r_data;
`else
                        w_state_nxt = S_IDLE;
                        w_valid_nxt = 1'b0;
`endif
                    end else begin
                        w_idx_nxt  = w_idx_inc;
                        w_data_nxt = w_snap_shift[7:0];
                    end
                end
            end
`ifdef SNAPSHOT_CSUM_EN
            S_CSUM: begin
                if (w_hs) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase

        if (w_accept) begin
            w_state_nxt = S_HDR;
            w_idx_nxt   = '0;
            w_data_nxt  = HEADER;
            w_valid_nxt = 1'b1;
        end
    end

    // Frame state and the registered stream outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Capture the nets and the frame's sequence number on an accepted trigger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the snapshot is a plain register bank, so it is cleared with the rest of the state.
            r_snap <= '0;
            r_seq  <= 8'h00;
            r_fseq <= 8'h00;
        end else if (w_accept) begin
            r_snap <= SNAP_W'(nets);
            r_fseq <= r_seq;
            r_seq  <= r_seq + 8'd1;
        end
    end

`ifdef SNAPSHOT_CSUM_EN
    // Running XOR of every byte already handed over in the current frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum <= 8'h00;
        end else if (w_accept) begin
            r_csum <= 8'h00;
        end else if (w_hs) begin
            r_csum <= r_csum ^ r_data;
        end
    end
`endif

    // Sticky overrun: a dropped trigger sets it and wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end else if (clr_ovr) begin
            r_ovr <= 1'b0;
        end
    end

    assign stream.out_data  = r_data;
    assign stream.out_valid = r_valid;
    assign busy             = r_busy;
    assign overrun          = r_ovr;

endmodule

// File: tb/tb_nor_bank_snapshot.sv
// Bench for nor_bank_snapshot: a WIDTH=32 and a WIDTH=12 instance, each checked
// every cycle against a frame-level model (queue of expected bytes plus a count
// of bytes still owed), with directed frame, overrun, wrap and reset scenarios
// and a randomized phase.
module tb_nor_bank_snapshot;

`ifdef SNAPSHOT_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int LEN0 = 6 + CS;
    localparam int LEN1 = 4 + CS;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] nets0 = '0;
    logic [11:0] nets1 = '0;
    logic        trig [2];
    logic        clr  [2];
    logic        rdy  [2];
    logic        busy0, busy1, ovr0, ovr1;

    nor_bank_snapshot_if s0 ();
    nor_bank_snapshot_if s1 ();

    assign s0.out_ready = rdy[0];
    assign s1.out_ready = rdy[1];

    nor_bank_snapshot #(.WIDTH(32)) dut0 (
        .clk(clk), .rst(rst), .nets(nets0), .trigger(trig[0]), .clr_ovr(clr[0]),
        .busy(busy0), .overrun(ovr0), .stream(s0)
    );

    nor_bank_snapshot #(.WIDTH(12)) dut1 (
        .clk(clk), .rst(rst), .nets(nets1), .trigger(trig[1]), .clr_ovr(clr[1]),
        .busy(busy1), .overrun(ovr1), .stream(s1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // ---------------- reference model ----------------
    int         rem   [2];
    bit         ovr_m [2];
    logic [7:0] seq_m [2];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] log0[$];
    logic [7:0] log1[$];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            rem[d] = 0; ovr_m[d] = 0; seq_m[d] = 8'h00;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic push_byte(input int d, input logic [7:0] b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic model_step(input int d, input logic [31:0] nv, input int nb);
        logic [7:0] frame[$];
        logic [7:0] x;
        if (rem[d] > 0 && rdy[d]) begin
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            rem[d]--;
        end
        if (trig[d] && rem[d] == 0) begin
            frame.push_back(8'hA5);
            frame.push_back(seq_m[d]);
            for (int i = 0; i < nb; i++) frame.push_back(nv[8*i +: 8]);
            if (CS != 0) begin
                x = 8'h00;
                for (int i = 0; i < frame.size(); i++) x ^= frame[i];
                frame.push_back(x);
            end
            for (int i = 0; i < frame.size(); i++) push_byte(d, frame[i]);
            rem[d] = frame.size();
            seq_m[d] = seq_m[d] + 8'd1;
            if (clr[d]) ovr_m[d] = 0;
        end else if (trig[d]) begin
            ovr_m[d] = 1;
        end else if (clr[d]) begin
            ovr_m[d] = 0;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else begin
            model_step(0, nets0, 4);
            model_step(1, {20'h0, nets1}, 2);
        end
    end

    // ---------------- per-cycle monitor ----------------
    task automatic mon(input int d, input logic v, input logic b, input logic o, input logic [7:0] dat);
        logic [7:0] f;
        check($sformatf("valid%0d", d), v, (rem[d] > 0));
        check($sformatf("busy%0d", d), b, (rem[d] > 0));
        check($sformatf("overrun%0d", d), o, ovr_m[d]);
        if (rem[d] > 0) begin
            f = (d == 0) ? q0[0] : q1[0];
            check($sformatf("data%0d", d), dat, f);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon(0, s0.out_valid, busy0, ovr0, s0.out_data);
            mon(1, s1.out_valid, busy1, ovr1, s1.out_data);
            if (s0.out_valid && rdy[0]) log0.push_back(s0.out_data);
            if (s1.out_valid && rdy[1]) log1.push_back(s1.out_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        trig[0] = 0; trig[1] = 0; clr[0] = 0; clr[1] = 0;
        rdy[0] = 1; rdy[1] = 1;
        for (int i = 0; i < 600; i++) begin
            if (rem[0] == 0 && rem[1] == 0) break;
            tick();
        end
        tick();
        check("drain busy0", busy0, 1'b0);
        check("drain busy1", busy1, 1'b0);
    endtask

    logic [7:0] exp_basic [7];

    initial begin
        exp_basic = '{8'hA5, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAD};
        for (int d = 0; d < 2; d++) begin
            trig[d] = 0; clr[d] = 0; rdy[d] = 0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst data0", s0.out_data, 8'h00);
        check("rst valid0", s0.out_valid, 1'b0);
        check("rst busy0", busy0, 1'b0);
        check("rst ovr0", ovr0, 1'b0);
        check("rst data1", s1.out_data, 8'h00);
        check("rst valid1", s1.out_valid, 1'b0);
        rst = 1;
        tick();

        // Basic frame; nets changed right after capture must not leak in.
        log0.delete();
        nets0 = 32'h12345678; rdy[0] = 1; trig[0] = 1;
        tick();
        trig[0] = 0; nets0 = $urandom;
        repeat (LEN0 + 2) tick();
        check("basic len", log0.size(), LEN0);
        for (int i = 0; i < LEN0 && i < log0.size(); i++)
            check($sformatf("basic byte%0d", i), log0[i], exp_basic[i]);

        // Backpressure with nets churning every cycle.
        for (int c = 0; c < 150; c++) begin
            rdy[0] = ($urandom_range(0, 2) != 0);
            trig[0] = ($urandom_range(0, 11) == 0);
            nets0 = $urandom;
            tick();
        end
        drain();

        // Overrun: dropped trigger sets it; a clear alongside a dropped trigger loses.
        clr[0] = 1; tick(); clr[0] = 0;
        trig[0] = 1; tick(); trig[0] = 0;
        tick();
        trig[0] = 1; tick(); trig[0] = 0;
        check("ovr set", ovr0, 1'b1);
        trig[0] = 1; clr[0] = 1; tick(); trig[0] = 0;
        check("ovr set wins", ovr0, 1'b1);
        tick(); clr[0] = 0;
        check("ovr cleared", ovr0, 1'b0);
        drain();

        // Back-to-back: trigger on the final byte's handshake.
        trig[0] = 1; tick(); trig[0] = 0;
        repeat (LEN0 - 1) tick();
        trig[0] = 1; tick(); trig[0] = 0;
        check("b2b valid", s0.out_valid, 1'b1);
        check("b2b header", s0.out_data, 8'hA5);
        check("b2b busy", busy0, 1'b1);
        check("b2b ovr", ovr0, 1'b0);
        drain();

        // Wrap and padding on the 12-bit instance: 257 back-to-back frames.
        log1.delete();
        nets1 = 12'hFFF; rdy[1] = 1; trig[1] = 1;
        repeat (256 * LEN1 + 1) tick();
        trig[1] = 0;
        drain();
        check("wrap len", log1.size(), 257 * LEN1);
        if (log1.size() == 257 * LEN1) begin
            check("wrap seq first", log1[1], 8'h00);
            check("wrap seq 255", log1[255 * LEN1 + 1], 8'hFF);
            check("wrap seq 256", log1[256 * LEN1 + 1], 8'h00);
            check("pad byte0", log1[2], 8'hFF);
            check("pad byte1", log1[3], 8'h0F);
        end
        clr[1] = 1; tick(); clr[1] = 0;

        // Reset in the middle of the data bytes.
        trig[0] = 1; tick(); trig[0] = 0;
        repeat (3) tick();
        #2 rst = 0;
        #1;
        check("midrst valid0", s0.out_valid, 1'b0);
        check("midrst busy0", busy0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        tick();
        log0.delete();
        trig[0] = 1; tick(); trig[0] = 0;
        repeat (LEN0 + 1) tick();
        check("post rst len", log0.size(), LEN0);
        if (log0.size() >= 2) begin
            check("post rst hdr", log0[0], 8'hA5);
            check("post rst seq", log0[1], 8'h00);
        end

        // Randomized traffic on both instances.
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 2; d++) begin
                rdy[d]  = ($urandom_range(0, 3) != 0);
                trig[d] = ($urandom_range(0, 9) == 0);
                clr[d]  = ($urandom_range(0, 15) == 0);
            end
            nets0 = $urandom;
            nets1 = 12'($urandom);
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
